// File: rtl/ddr3_mp_frontend_if.sv
// Bundle between the requester ports, the multi-port front-end and the DDR3 processing logic.
// The front-end takes the slave side; requesters, consumer and return source take the master side.
interface ddr3_mp_frontend_if #(
    parameter int NPORTS = 2,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 26,
    parameter int DATA_W = 16,
    parameter int PW     = 3
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [NPORTS-1:0]        req_valid;
    logic [NPORTS-1:0]        req_ready;
    logic [NPORTS*3-1:0]      req_cmd;
    logic [NPORTS*2-1:0]      req_sz;
    logic [NPORTS*3-1:0]      req_op;
    logic [NPORTS*ADDR_W-1:0] req_addr;
    logic [NPORTS*CW-1:0]     fillcount;

    logic                     cmd_valid;
    logic                     cmd_get;
    logic [8+ADDR_W-1:0]      cmd_data;
    logic [PW-1:0]            cmd_port;

    logic                     ret_valid;
    logic                     ret_last;
    logic [PW-1:0]            ret_port;
    logic [ADDR_W-1:0]        ret_addr;
    logic [DATA_W-1:0]        ret_data;

    logic [NPORTS-1:0]        rsp_valid;
    logic [ADDR_W-1:0]        rsp_addr;
    logic [DATA_W-1:0]        rsp_data;
    logic [NPORTS*4-1:0]      outstanding;

    modport slave (
        input  req_valid, req_cmd, req_sz, req_op, req_addr,
        output req_ready, fillcount,
        output cmd_valid, cmd_data, cmd_port,
        input  cmd_get,
        input  ret_valid, ret_last, ret_port, ret_addr, ret_data,
        output rsp_valid, rsp_addr, rsp_data, outstanding
    );

    modport master (
        output req_valid, req_cmd, req_sz, req_op, req_addr,
        input  req_ready, fillcount,
        input  cmd_valid, cmd_data, cmd_port,
        output cmd_get,
        output ret_valid, ret_last, ret_port, ret_addr, ret_data,
        input  rsp_valid, rsp_addr, rsp_data, outstanding
    );
endinterface

// File: rtl/ddr3_mp_frontend.sv
// Multi-port DDR3 request front-end: per-port command FIFOs, round-robin merge into one
// registered command slot, per-port outstanding-read limiting and tagged return routing.
module ddr3_mp_frontend #(
    parameter int NPORTS  = 2,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 16,
    parameter int MAX_OUT = 4,
    parameter int PW      = 3
) (
    input  logic              clk,
    input  logic              reset,
    ddr3_mp_frontend_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int CMD_W = 8 + ADDR_W;

    logic [NPORTS-1:0][CMD_W-1:0] head;
    logic [NPORTS-1:0]            elig;
    logic [NPORTS-1:0]            pop;

    logic              cmd_valid_q, cmd_valid_d;
    logic [CMD_W-1:0]  cmd_data_q, cmd_data_d;
    logic [PW-1:0]     cmd_port_q, cmd_port_d;
    logic [PW-1:0]     rr_q, rr_d;
    logic              slot_free;
    logic              win_found;
    logic [PW-1:0]     win;

    logic [NPORTS-1:0] rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0] rsp_addr_q;
    logic [DATA_W-1:0] rsp_data_q;

    assign slot_free = !cmd_valid_q || bus.cmd_get;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        logic [DEPTH-1:0][CMD_W-1:0] mem_q;
        logic [AW-1:0]               wr_q, rd_q;
        logic [CW-1:0]               cnt_q, cnt_d;
        logic [3:0]                  out_q, out_d;
        logic                        push, is_rd, inc, dec;

        assign bus.req_ready[p]             = (cnt_q != CW'(DEPTH));
        assign push                         = bus.req_valid[p] && bus.req_ready[p];
        assign head[p]                      = mem_q[rd_q];
        assign is_rd                        = (head[p][CMD_W-1 -: 3] == 3'b001);
        // A blocked read at the head also blocks everything queued behind it on this port.
        assign elig[p]                      = (cnt_q != '0) && (!is_rd || out_q < 4'(MAX_OUT));
        assign inc                          = pop[p] && is_rd;
        assign dec                          = bus.ret_valid && bus.ret_last && (bus.ret_port == PW'(p));
        assign bus.fillcount[CW*p +: CW]    = cnt_q;
        assign bus.outstanding[4*p +: 4]    = out_q;

        always_comb begin
            cnt_d = cnt_q;
            if (push && !pop[p])      cnt_d = cnt_q + 1'b1;
            else if (!push && pop[p]) cnt_d = cnt_q - 1'b1;
            out_d = out_q;
            if (inc && !dec)                      out_d = out_q + 1'b1;
            else if (dec && !inc && out_q != '0)  out_d = out_q - 1'b1;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
                out_q <= '0;
            end else begin
                if (push)   wr_q <= wr_q + 1'b1;
                if (pop[p]) rd_q <= rd_q + 1'b1;
                cnt_q <= cnt_d;
                out_q <= out_d;
            end
        end

        always_ff @(posedge clk) begin
            if (push)
                mem_q[wr_q] <= {bus.req_cmd[3*p +: 3], bus.req_sz[2*p +: 2],
                                bus.req_op[3*p +: 3], bus.req_addr[ADDR_W*p +: ADDR_W]};
        end
    end

    // Rotating priority scan starting at rr_q.
    always_comb begin
        win_found = 1'b0;
        win       = '0;
        for (int i = 0; i < NPORTS; i++) begin
            for (int j = 0; j < NPORTS; j++) begin
                if (!win_found && elig[j] &&
                    (((int'(rr_q) + i) >= NPORTS) ? (int'(rr_q) + i - NPORTS) : (int'(rr_q) + i)) == j) begin
                    win_found = 1'b1;
                    win       = PW'(j);
                end
            end
        end
    end

    always_comb begin
        pop         = '0;
        cmd_valid_d = cmd_valid_q;
        cmd_data_d  = cmd_data_q;
        cmd_port_d  = cmd_port_q;
        rr_d        = rr_q;
        if (slot_free) begin
            cmd_valid_d = win_found;
            if (win_found) begin
                for (int j = 0; j < NPORTS; j++) begin
                    if (win == PW'(j)) begin
                        pop[j]     = 1'b1;
                        cmd_data_d = head[j];
                    end
                end
                cmd_port_d = win;
                rr_d       = (win == PW'(NPORTS-1)) ? '0 : win + 1'b1;
            end
        end
    end

    // Tags outside the port range decode to no strobe and so are dropped.
    always_comb begin
        rsp_valid_d = '0;
        for (int j = 0; j < NPORTS; j++)
            rsp_valid_d[j] = bus.ret_valid && (bus.ret_port == PW'(j));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= '0;
            cmd_port_q  <= '0;
            rr_q        <= '0;
            rsp_valid_q <= '0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
        end else begin
            cmd_valid_q <= cmd_valid_d;
            cmd_data_q  <= cmd_data_d;
            cmd_port_q  <= cmd_port_d;
            rr_q        <= rr_d;
            rsp_valid_q <= rsp_valid_d;
            if (|rsp_valid_d) begin
                rsp_addr_q <= bus.ret_addr;
                rsp_data_q <= bus.ret_data;
            end
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_data  = cmd_data_q;
    assign bus.cmd_port  = cmd_port_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: doc/ddr3_mp_frontend.md
Name: ddr3_mp_frontend

Overview:
- Parametrised multi-port request front-end for the DDR3 controller. It replaces the single command FIFO with NPORTS per-port command FIFOs.
- A round-robin arbiter merges the ports into one registered command stream. The stream carries a port tag and is consumed by the processing logic.
- Tagged read returns from the processing logic are routed back to the issuing port.
- A per-port outstanding-read limit stops any one port from monopolising the return path.

Parameters:
- NPORTS, 2, number of requester ports (2..8).
- DEPTH, 8, entries per port command FIFO (power of 2, >=2).
- ADDR_W, 26, address width.
- DATA_W, 16, return data width.
- MAX_OUT, 4, maximum outstanding reads per port (1..15).
- PW, 3, port-tag width (must satisfy 2**PW >= NPORTS).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NPORTS  per-port request strobe
- req_ready  out  NPORTS  per-port FIFO not full
- req_cmd  in  NPORTS*3  per-port cmd; port p occupies bits [3p+2:3p]; 3'b001 = read
- req_sz  in  NPORTS*2  per-port size
- req_op  in  NPORTS*3  per-port op
- req_addr  in  NPORTS*ADDR_W  per-port address
- fillcount  out  NPORTS*(log2(DEPTH)+1)  per-port FIFO occupancy
- cmd_valid  out  1  merged command available
- cmd_get  in  1  consumer accepts merged command
- cmd_data  out  8+ADDR_W  merged command {cmd,sz,op,addr}
- cmd_port  out  PW  source port of cmd_data
- ret_valid  in  1  return beat valid
- ret_last  in  1  last beat of a read burst
- ret_port  in  PW  port tag of return beat
- ret_addr  in  ADDR_W  return address
- ret_data  in  DATA_W  return data
- rsp_valid  out  NPORTS  one-hot return strobe
- rsp_addr  out  ADDR_W  registered return address
- rsp_data  out  DATA_W  registered return data
- outstanding  out  NPORTS*4  per-port outstanding-read count

Behaviour:
- Reset values: all FIFOs empty; fillcount=0; req_ready=all 1; cmd_valid=0; cmd_data=0; cmd_port=0; rsp_valid=0; rsp_addr=0; rsp_data=0; outstanding=0; RR pointer=0. Reset mid-operation discards all queued and outstanding state on the next edge.
- Enqueue: on an edge with req_valid[p]&req_ready[p], the request is written to FIFO p. req_ready[p] = (fillcount[p] != DEPTH). A write attempted while full is ignored and does not corrupt state.
- Eligibility: port p is eligible when FIFO p is non-empty. If the head entry is a read, p additionally requires outstanding[p] < MAX_OUT.
- Output stage: a single register slot. The slot is free when !cmd_valid or cmd_get.
- Arbitration: when the slot is free, the winner is the first eligible port scanning from rr_ptr upward with wrap-around.
  - Next edge: the head is popped into cmd_data/cmd_port and cmd_valid=1.
  - rr_ptr <= winner+1 mod NPORTS.
  - If no port is eligible, cmd_valid <= 0 and rr_ptr is unchanged.
- Latency: a request enqueued at edge N reaches cmd_valid at edge N+1 at the earliest (empty system, slot free).
- Throughput: one command per cycle with cmd_get held high.
- Hold: while cmd_valid & !cmd_get, cmd_data and cmd_port are stable and no FIFO pops.
- Outstanding accounting: outstanding[p] +1 when a read is popped from FIFO p into the slot. It is -1 on ret_valid&ret_last&ret_port==p.
- Simultaneous increment and decrement on the same port leaves the count unchanged.
- A decrement at 0 is a protocol error: the count saturates at 0.
- A ret_port >= NPORTS is dropped, with no rsp_valid and no count change.
- Return path: ret_valid at edge N registers rsp_valid=onehot(ret_port), rsp_addr and rsp_data at edge N+1. There is no backpressure, and rsp_valid is a single-cycle pulse per beat.
- Writes and other commands never touch the outstanding counters.

Test Plan:
- Reset then idle: rsp_valid=0, cmd_valid=0, req_ready=2'b11, fillcount=0 for all ports.
- Single port: port0 issues a write, addr=0x0000100, with cmd_get=1. cmd_valid rises one edge later with cmd_port=0 and cmd_data={3'b010,sz,op,0x0000100}.
- Fairness: both ports continuously valid with 4 commands each and cmd_get=1. Output cmd_port sequence is 0,1,0,1,0,1,0,1.
- Full FIFO: port1 pushes 9 requests with cmd_get=0. The first enters the slot, entries 2-9 fill FIFO1, and then req_ready[1]=0 with fillcount[1]=8. A 10th push is ignored. After cmd_get is released, exactly 9 commands emerge in order.
- Outstanding limit: port0 issues 5 reads, MAX_OUT=4, no returns. Only 4 reach cmd_valid and outstanding[0]=4. One ret_valid&ret_last with ret_port=0 releases the 5th, and the count returns to 4.
- Return routing: ret_valid with ret_port=1, ret_addr=0x12345, ret_data=0xBEEF gives rsp_valid=2'b10, rsp_addr=0x12345 and rsp_data=0xBEEF one edge later. ret_port=5 with NPORTS=2 gives no rsp_valid.
